flash_bus_arbiter: RTL
======================

// Module: flash_bus_arbiter
// PURPOSE
//  Owns the shared CFI flash address/control bus between the PFL configurator and the
//  user flash controller (flash_control_MM), replacing the hard select mux in sys_cpld_top.
//  Grants the bus with a request/grant handshake and inserts parked turnaround cycles
//  between owners. Bounds user ownership with a watchdog.
//  Sits in sys_cpld_top between both masters and the fsm_a/flash_* pins.
// PARAMETERS
//  ADDR_W      25          flash word-address width (fsm_a[25:1])
//  TURN_CYCLES 4           parked-bus cycles before any grant (1..15)
//  USR_TMO     24'hFFFFFF  max user-ownership cycles before forced release
// PORTS
//  clkin_max_100  in   1       100 MHz clock
//  sys_resetn     in   1       async active-low reset
//  pfl_req        in   1       PFL pfl_flash_access_request
//  pfl_gnt        out  1       PFL pfl_flash_access_granted
//  usr_req        in   1       user controller request, level, active-high
//  usr_done       in   1       user controller wr_done, 1-cycle pulse
//  usr_gnt        out  1       user controller ownership (fc_flash_contr, active-high)
//  pfl_cen/oen/wen/advn in 1   PFL bus controls, active-low
//  pfl_addr       in   ADDR_W  PFL address
//  usr_cen/oen/wen/advn in 1   user bus controls, active-low
//  usr_addr       in   ADDR_W  user address
//  flash_cen/oen/wen/advn out 1  pin controls
//  fsm_a          out  ADDR_W  pin address
//  err_clr        in   1       clears tmo_err
//  tmo_err        out  1       sticky: user watchdog fired
//  arb_state      out  3       current state encoding, for max_leds
// BEHAVIOUR
//  Reset: state IDLE, pfl_gnt=0, usr_gnt=0, tmo_err=0, last_owner=USR (PFL wins first tie),
//   turn/timeout counters 0, pins parked: cen=oen=wen=advn=1, fsm_a=0.
//  States (arb_state): IDLE=0, TURN_PFL=1, PFL_OWN=2, TURN_USR=3, USR_OWN=4.
//  IDLE: both req -> TURN toward owner != last_owner; one req -> TURN toward it; none -> stay.
//  TURN_x: bus parked, count 0..TURN_CYCLES-1, then -> x_OWN. Grant rises on the
//   entry edge into x_OWN. Request drop during TURN -> IDLE, no grant.
//  PFL_OWN: pfl_gnt=1 while pfl_req=1. pfl_req=0 -> pfl_gnt=0 next edge, last_owner=PFL, IDLE.
//   Never preempted by usr_req.
//  USR_OWN: usr_gnt=1; timeout counter increments each cycle. Release on usr_done=1,
//   usr_req=0, or counter==USR_TMO (also sets tmo_err). Release -> usr_gnt=0,
//   last_owner=USR, IDLE. Not preempted by pfl_req; PFL waits.
//  usr_done and timeout on the same cycle: normal release, tmo_err not set.
//  Pin mux: combinational from registered grants: pfl_gnt -> pfl_*, usr_gnt -> usr_*,
//   neither -> parked. Zero-latency path; grants never both 1 (assertion).
//  fsm_d is not muxed: each master tristates fsm_d when not granted.
//  tmo_err: set has priority over err_clr on the same cycle.
//  Reset mid-ownership: grants drop and pins park asynchronously; masters restart handshake.
// STRUCTURE
//  Shared package flash_bus_pkg: state encodings, parked-bus constant {cen,oen,wen,advn}=4'hF.
//  One sub-module: flash_bus_mux (combinational grant-selected pin mux).
//  FSM, turn counter (4 b) and timeout counter (24 b) live in the top.
// TESTING
//  Reset, pfl_req=1 -> 4 parked cycles, pfl_gnt=1 at edge 5; fsm_a follows pfl_addr at once.
//  pfl_req and usr_req both 1 after PFL session -> user granted next; pins park 4 cycles between.
//  PFL_OWN, usr_req=1 -> no usr_gnt until pfl_req=0; then turn, usr_gnt=1.
//  USR_OWN with USR_TMO=16, no usr_done -> usr_gnt=0 after 17 cycles, tmo_err=1; err_clr -> 0.
//  usr_done coincident with timeout -> release, tmo_err=0.
//  sys_resetn low during USR_OWN -> usr_gnt=0 and flash_cen=1 without a clock edge.

Source files
------------

// File: rtl/flash_bus_pkg.sv
// Shared definitions for the CFI flash bus arbiter: state encodings, owner tags
// and the parked-bus control value.
package flash_bus_pkg;

   typedef enum logic [2:0] {
      ST_IDLE     = 3'd0,
      ST_TURN_PFL = 3'd1,
      ST_PFL_OWN  = 3'd2,
      ST_TURN_USR = 3'd3,
      ST_USR_OWN  = 3'd4
   } arb_state_e;

   typedef enum logic {
      OWNER_PFL = 1'b0,
      OWNER_USR = 1'b1
   } owner_e;

   // {cen, oen, wen, advn}, all active-low, so a parked bus is all ones
   localparam logic [3:0] PARK_CTRL = 4'hF;

   localparam int TURN_W = 4;
   localparam int TMO_W  = 24;

endpackage

// File: rtl/flash_bus_mux.sv
// Grant-selected pin mux: hands the flash control/address pins to whichever
// master holds a registered grant, otherwise drives the parked bus.
module flash_bus_mux
   import flash_bus_pkg::*;
#(
   parameter int ADDR_W = 25
) (
   input  logic              pfl_gnt,
   input  logic              usr_gnt,
   input  logic [3:0]        pfl_ctrl,
   input  logic [3:0]        usr_ctrl,
   input  logic [ADDR_W-1:0] pfl_addr,
   input  logic [ADDR_W-1:0] usr_addr,
   output logic [3:0]        pin_ctrl,
   output logic [ADDR_W-1:0] pin_addr
);

   always_comb begin
      pin_ctrl = PARK_CTRL;
      pin_addr = '0;
      if (pfl_gnt) begin
         pin_ctrl = pfl_ctrl;
         pin_addr = pfl_addr;
      end else if (usr_gnt) begin
         pin_ctrl = usr_ctrl;
         pin_addr = usr_addr;
      end
   end

endmodule

// File: rtl/flash_bus_arbiter.sv
// Arbitrates the shared CFI flash bus between the PFL configurator and the user
// flash controller, with parked turnaround cycles and a user-ownership watchdog.
module flash_bus_arbiter
   import flash_bus_pkg::*;
#(
   parameter int          ADDR_W      = 25,
   parameter int          TURN_CYCLES = 4,
   parameter logic [23:0] USR_TMO     = 24'hFFFFFF
) (
   input  logic              clkin_max_100,
   input  logic              sys_resetn,
   input  logic              pfl_req,
   output logic              pfl_gnt,
   input  logic              usr_req,
   input  logic              usr_done,
   output logic              usr_gnt,
   input  logic              pfl_cen,
   input  logic              pfl_oen,
   input  logic              pfl_wen,
   input  logic              pfl_advn,
   input  logic [ADDR_W-1:0] pfl_addr,
   input  logic              usr_cen,
   input  logic              usr_oen,
   input  logic              usr_wen,
   input  logic              usr_advn,
   input  logic [ADDR_W-1:0] usr_addr,
   output logic              flash_cen,
   output logic              flash_oen,
   output logic              flash_wen,
   output logic              flash_advn,
   output logic [ADDR_W-1:0] fsm_a,
   input  logic              err_clr,
   output logic              tmo_err,
   output logic [2:0]        arb_state
);

   localparam logic [TURN_W-1:0] TURN_LAST = TURN_W'(TURN_CYCLES - 1);

   arb_state_e        state_q, state_d;
   owner_e            last_owner_q, last_owner_d;
   logic [TURN_W-1:0] turn_cnt_q, turn_cnt_d;
   logic [TMO_W-1:0]  tmo_cnt_q, tmo_cnt_d;
   logic              tmo_err_q, tmo_err_d;
   logic              pfl_gnt_q, pfl_gnt_d;
   logic              usr_gnt_q, usr_gnt_d;
   logic              tmo_fire;
   logic [3:0]        pin_ctrl;

   always_ff @(posedge clkin_max_100 or negedge sys_resetn) begin
      if (!sys_resetn) begin
         state_q      <= ST_IDLE;
         last_owner_q <= OWNER_USR;
         turn_cnt_q   <= '0;
         tmo_cnt_q    <= '0;
         tmo_err_q    <= 1'b0;
         pfl_gnt_q    <= 1'b0;
         usr_gnt_q    <= 1'b0;
      end else begin
         state_q      <= state_d;
         last_owner_q <= last_owner_d;
         turn_cnt_q   <= turn_cnt_d;
         tmo_cnt_q    <= tmo_cnt_d;
         tmo_err_q    <= tmo_err_d;
         pfl_gnt_q    <= pfl_gnt_d;
         usr_gnt_q    <= usr_gnt_d;
      end
   end

   always_comb begin
      state_d      = state_q;
      last_owner_d = last_owner_q;
      turn_cnt_d   = '0;
      tmo_cnt_d    = '0;
      tmo_fire     = 1'b0;
      unique case (state_q)
         ST_IDLE: begin
            // On a tie, alternate away from whoever held the bus last
            if (pfl_req && usr_req)
               state_d = (last_owner_q == OWNER_USR) ? ST_TURN_PFL : ST_TURN_USR;
            else if (pfl_req)
               state_d = ST_TURN_PFL;
            else if (usr_req)
               state_d = ST_TURN_USR;
         end
         ST_TURN_PFL: begin
            if (!pfl_req)
               state_d = ST_IDLE;
            else if (turn_cnt_q == TURN_LAST)
               state_d = ST_PFL_OWN;
            else
               turn_cnt_d = turn_cnt_q + 1'b1;
         end
         ST_TURN_USR: begin
            if (!usr_req)
               state_d = ST_IDLE;
            else if (turn_cnt_q == TURN_LAST)
               state_d = ST_USR_OWN;
            else
               turn_cnt_d = turn_cnt_q + 1'b1;
         end
         ST_PFL_OWN: begin
            if (!pfl_req) begin
               state_d      = ST_IDLE;
               last_owner_d = OWNER_PFL;
            end
         end
         ST_USR_OWN: begin
            // A genuine completion wins over a watchdog expiry in the same cycle
            if (usr_done || !usr_req) begin
               state_d      = ST_IDLE;
               last_owner_d = OWNER_USR;
            end else if (tmo_cnt_q == USR_TMO) begin
               state_d      = ST_IDLE;
               last_owner_d = OWNER_USR;
               tmo_fire     = 1'b1;
            end else begin
               tmo_cnt_d = tmo_cnt_q + 1'b1;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      pfl_gnt_d = (state_d == ST_PFL_OWN);
      usr_gnt_d = (state_d == ST_USR_OWN);
      tmo_err_d = tmo_fire ? 1'b1 : (err_clr ? 1'b0 : tmo_err_q);
      arb_state = state_q;
   end

   flash_bus_mux #(.ADDR_W(ADDR_W)) u_mux (
      .pfl_gnt  (pfl_gnt_q),
      .usr_gnt  (usr_gnt_q),
      .pfl_ctrl ({pfl_cen, pfl_oen, pfl_wen, pfl_advn}),
      .usr_ctrl ({usr_cen, usr_oen, usr_wen, usr_advn}),
      .pfl_addr (pfl_addr),
      .usr_addr (usr_addr),
      .pin_ctrl (pin_ctrl),
      .pin_addr (fsm_a)
   );

   assign {flash_cen, flash_oen, flash_wen, flash_advn} = pin_ctrl;
   assign pfl_gnt = pfl_gnt_q;
   assign usr_gnt = usr_gnt_q;
   assign tmo_err = tmo_err_q;

   assert property (@(posedge clkin_max_100) disable iff (!sys_resetn)
                    !(pfl_gnt_q && usr_gnt_q));

endmodule
